// File: rtl/modport_mem_pkg.sv
// Shared types and sizing for the PicoRV32 native-bus memory responder.
// Holds the bus FSM encoding and the width constants used by the top and the register shadow.
package modport_mem_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_IDX_W  = 5;
  localparam int MEM_BYTES  = 4096;
  localparam int BYTE_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/modport_reg_shadow.sv
// Shadow copy of the CPU register file (x1..x31) fed by writeback strobes,
// with a writeback counter and a combinational debug read port.
module modport_reg_shadow
  import modport_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cpuregs_write,
  input  logic [REG_IDX_W-1:0] latched_rd,
  input  logic [DATA_W-1:0]    cpuregs_wrdata,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [31:0]          wb_count
);

  logic [DATA_W-1:0] regs [32];
  logic              wb_take;

  assign wb_take = cpuregs_write && (latched_rd != '0);

  // x0 is hardwired to zero, so it has no storage behind it.
  assign regs[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q_reg <= '0;
      end else if (cpuregs_write && latched_rd == REG_IDX_W'(gi)) begin
        q_reg <= cpuregs_wrdata;
      end
    end

    assign regs[gi] = q_reg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_count <= '0;
    end else if (wb_take) begin
      wb_count <= wb_count + 32'd1;
    end
  end

  // Reads see the registered value only; a same-cycle write is not forwarded.
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/modport_mem_slave.sv
// Memory-side responder for the PicoRV32 native bus: word RAM with byte-strobed writes,
// programmable response latency, backdoor load port and a register-file shadow.
module modport_mem_slave
  import modport_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_BYTES / 4,
  parameter int LATENCY   = 1
)
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [DATA_W-1:0]    mem_rdata,
  input  logic                 cpuregs_write,
  input  logic [REG_IDX_W-1:0] latched_rd,
  input  logic [DATA_W-1:0]    cpuregs_wrdata,
  input  logic                 ld_en,
  input  logic [9:0]           ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [31:0]          wb_count,
  output logic                 bus_err
);

  localparam int                IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(4 * MEM_WORDS);

  bus_state_e        state_reg;
  logic [3:0]        wait_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [3:0]        wstrb_reg;

  logic [DATA_W-1:0] ram [MEM_WORDS];

  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic              addr_bad;
  logic              enter_resp;
  logic              bus_write;

  assign word_idx   = addr_reg[IDX_W+1:2];
  assign ld_idx     = IDX_W'(ld_addr);
  assign addr_bad   = (addr_reg >= MEM_LIMIT) || (addr_reg[1:0] != 2'b00);
  assign enter_resp = (state_reg == WAIT) && (wait_cnt_reg == 4'd0);
  assign bus_write  = enter_resp && (wstrb_reg != 4'b0000) && !addr_bad;

  // Every request passes through WAIT at least once, so mem_ready lands
  // LATENCY+1 edges after the accepting edge, including LATENCY=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      bus_err      <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_valid) begin
            addr_reg     <= mem_addr;
            wdata_reg    <= mem_wdata;
            wstrb_reg    <= mem_wstrb;
            wait_cnt_reg <= 4'(LATENCY);
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= RESP;
            mem_ready <= 1'b1;
            if (wstrb_reg == 4'b0000) begin
              mem_rdata <= addr_bad ? '0 : ram[word_idx];
            end
            if (addr_bad) begin
              bus_err <= 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // RAM is deliberately not reset; a bus write to the same word beats the backdoor.
  always_ff @(posedge clk) begin
    if (ld_en && !(bus_write && ld_idx == word_idx)) begin
      ram[ld_idx] <= ld_data;
    end
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (bus_write && wstrb_reg[i]) begin
        ram[word_idx][8*i +: 8] <= wdata_reg[8*i +: 8];
      end
    end
  end

  modport_reg_shadow u_reg_shadow (
    .clk            (clk),
    .resetn         (resetn),
    .cpuregs_write  (cpuregs_write),
    .latched_rd     (latched_rd),
    .cpuregs_wrdata (cpuregs_wrdata),
    .dbg_sel        (dbg_sel),
    .dbg_data       (dbg_data),
    .wb_count       (wb_count)
  );

endmodule

// File: tb/tb_modport_mem_slave.sv
// Randomized bench for modport_mem_slave: three instances (LATENCY 1, 0, 3) share one stimulus
// and are checked against a word-array memory model and a register-file shadow model.
module tb_modport_mem_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpuregs_write;
  logic [4:0]  latched_rd;
  logic [31:0] cpuregs_wrdata;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_sel;

  logic        mem_ready [3];
  logic [31:0] mem_rdata [3];
  logic [31:0] dbg_data  [3];
  logic [31:0] wb_count  [3];
  logic        bus_err   [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    modport_mem_slave #(.MEM_WORDS(1024), .LATENCY(LAT)) u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .mem_valid      (mem_valid),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_ready      (mem_ready[gi]),
      .mem_rdata      (mem_rdata[gi]),
      .cpuregs_write  (cpuregs_write),
      .latched_rd     (latched_rd),
      .cpuregs_wrdata (cpuregs_wrdata),
      .ld_en          (ld_en),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .dbg_sel        (dbg_sel),
      .dbg_data       (dbg_data[gi]),
      .wb_count       (wb_count[gi]),
      .bus_err        (bus_err[gi])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m    [1024];
  logic [31:0] shadow_m [32];
  logic [31:0] wbc_m;
  bit          err_m;
  logic [31:0] prev_rd  [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return (a >= 32'd4096) || (a % 4 != 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) shadow_m[r] = '0;
    wbc_m = '0;
    err_m = 1'b0;
    for (int d = 0; d < 3; d++) prev_rd[d] = '0;
  endtask

  task automatic backdoor(input int idx, input logic [31:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = data;
    mem_m[idx] = data;
  endtask

  // One bus transaction; valid is held for a single sampling edge only, then
  // the bus is scrambled to show the responder works from its latched copy.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int          lat    [3];
    int          pulses [3];
    logic [31:0] got    [3];
    logic [31:0] exp_rd [3];
    int          idx;
    bit          bad;
    idx = int'(addr / 4) % 1024;
    bad = out_of_range(addr);
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; pulses[d] = 0; got[d] = 'x;
    end
    @(negedge clk);
    ld_en     = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    mem_wstrb = 4'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (mem_ready[d] === 1'b1) begin
          pulses[d]++;
          if (lat[d] < 0) begin
            lat[d] = k;
            got[d] = mem_rdata[d];
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (wstrb == 4'b0000) exp_rd[d] = bad ? 32'h0 : mem_m[idx];
      else                  exp_rd[d] = prev_rd[d];
    end
    if (bad) err_m = 1'b1;
    else if (wstrb != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("ready_latency[%0d]", d), 32'(lat[d]), 32'(lat_of(d) + 1));
      chk($sformatf("ready_pulses[%0d]", d), 32'(pulses[d]), 32'd1);
      chk($sformatf("rdata[%0d]", d), got[d], exp_rd[d]);
      chk($sformatf("bus_err[%0d]", d), 32'(bus_err[d]), 32'(err_m));
      prev_rd[d] = exp_rd[d];
    end
    $display("xfer addr=%h wstrb=%b wdata=%h rdata=%h/%h/%h lat=%0d/%0d/%0d",
             addr, wstrb, wdata, got[0], got[1], got[2], lat[0], lat[1], lat[2]);
  endtask

  // Each step commits whatever the previous step drove, checks the debug port,
  // then drives the next writeback/select pair.
  task automatic wb_step(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic [4:0] sel);
    @(negedge clk);
    if (cpuregs_write && latched_rd != 5'd0) begin
      shadow_m[latched_rd] = cpuregs_wrdata;
      wbc_m++;
      $display("wb x%0d <= %h count=%0d", latched_rd, cpuregs_wrdata, wbc_m);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dbg_x%0d[%0d]", dbg_sel, d), dbg_data[d], shadow_m[dbg_sel]);
      chk($sformatf("wb_count[%0d]", d), wb_count[d], wbc_m);
    end
    cpuregs_write  = we;
    latched_rd     = rd;
    cpuregs_wrdata = data;
    dbg_sel        = sel;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          r;

    resetn = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    cpuregs_write = 1'b0; latched_rd = '0; cpuregs_wrdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_sel = 5'd5;
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(mem_ready[d]), 32'd0);
      chk("rst_rdata", mem_rdata[d], 32'd0);
      chk("rst_wb_count", wb_count[d], 32'd0);
      chk("rst_bus_err", 32'(bus_err[d]), 32'd0);
      chk("rst_dbg", dbg_data[d], 32'd0);
    end
    resetn = 1'b1;

    for (int i = 0; i < 1024; i++) backdoor(i, $urandom);
    backdoor(4, 32'hDEADBEEF);
    backdoor(0, 32'h11223344);

    bus_xfer(32'h10, 32'h0, 4'b0000);
    chk("read_deadbeef", mem_rdata[0], 32'hDEADBEEF);
    bus_xfer(32'h0, 32'hAABBCCDD, 4'b0101);
    bus_xfer(32'h0, 32'h0, 4'b0000);
    chk("strobe_merge", mem_rdata[0], 32'h11BB33DD);
    chk("strobe_no_err", 32'(bus_err[0]), 32'd0);

    wb_step(1'b1, 5'd5, 32'h12345678, 5'd0);
    wb_step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd5);
    wb_step(1'b0, 5'd0, 32'h0, 5'd0);
    chk("wb_count_one", wb_count[0], 32'd1);
    wb_step(1'b1, 5'd5, 32'hCAFEF00D, 5'd5);
    #1 chk("no_bypass", dbg_data[0], 32'h12345678);
    wb_step(1'b0, 5'd0, 32'h0, 5'd5);
    for (int i = 0; i < 80; i++)
      wb_step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
    wb_step(1'b0, 5'd0, 32'h0, 5'd5);

    bus_xfer(32'h1000, 32'h0, 4'b0000);
    chk("oor_read_err", 32'(bus_err[0]), 32'd1);
    bus_xfer(32'h2000, $urandom, 4'b1111);
    bus_xfer(32'h13, 32'h0, 4'b0000);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(1024, 65535)) << 2;
      else if (r == 1) a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 1023)) << 2;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      bus_xfer(a, $urandom, s);
    end
    for (int i = 0; i < 24; i++) bus_xfer(32'($urandom_range(0, 1023)) << 2, 32'h0, 4'b0000);

    // Reset while the LATENCY=1/3 instances sit in WAIT and LATENCY=0 is responding.
    @(negedge clk);
    dbg_sel   = 5'd5;
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_ready_l1", 32'(mem_ready[0]), 32'd0);
    chk("pre_rst_ready_l0", 32'(mem_ready[1]), 32'd1);
    chk("pre_rst_err_sticky", 32'(bus_err[0]), 32'd1);
    chk("pre_rst_wb_count", wb_count[0], wbc_m);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_rst_ready[%0d]", d), 32'(mem_ready[d]), 32'd0);
      chk($sformatf("async_rst_err[%0d]", d), 32'(bus_err[d]), 32'd0);
      chk($sformatf("async_rst_wb[%0d]", d), wb_count[d], 32'd0);
      chk($sformatf("async_rst_dbg[%0d]", d), dbg_data[d], 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    bus_xfer(32'h10, 32'h0, 4'b0000);
    bus_xfer(32'h0, 32'h0, 4'b0000);
    wb_step(1'b1, 5'd9, 32'h0BADF00D, 5'd9);
    wb_step(1'b0, 5'd0, 32'h0, 5'd9);
    wb_step(1'b0, 5'd0, 32'h0, 5'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
